// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring UDIV/SDIV with start/busy/done handshake
module div_unit #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] dvd, dvs, rem, rem_nx, quo_nx, abs_a, abs_b;
  logic [N:0] r_sh, diff;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, sa, sb, ge, b_zero;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign b_zero = b == '0;
  always_comb begin
    sa = is_signed & a[N-1];
    sb = is_signed & b[N-1];
    abs_a = sa ? -a : a;
    abs_b = sb ? -b : b;
    r_sh = {rem, dvd[N-1]};
    diff = r_sh - {1'b0, dvs};
    ge = ~diff[N];
    rem_nx = ge ? diff[N-1:0] : r_sh[N-1:0];
    quo_nx = {dvd[N-2:0], ge};
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? (b_zero ? DONE : RUN) : IDLE) :
               state == RUN  ? (cnt == '0 ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!reset) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      quotient <= '0;
      remainder <= b_zero ? a : '0;
      div_by_zero <= b_zero;
      if (!b_zero) begin
        dvd <= abs_a;
        dvs <= abs_b;
        rem <= '0;
        cnt <= CNT_MAX;
        neg_q <= sa ^ sb;
        neg_r <= sa;
      end
    end else if (state == RUN) begin
      rem <= rem_nx;
      dvd <= quo_nx;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        quotient <= neg_q ? -quo_nx : quo_nx;
        remainder <= neg_r ? -rem_nx : rem_nx;
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit
module tb_div_unit;
  logic clk = 1'b0, reset = 1'b0, is_signed = 1'b0, start = 1'b0;
  logic [63:0] a = '0, b = '0, quotient, remainder;
  logic busy, done, div_by_zero;
  logic [128:0] sb_q[$];
  logic [128:0] exp_r;
  int total = 0, bad = 0, dones;
  always #5 clk = ~clk;
  div_unit #(.N(64)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .is_signed(is_signed), .start(start),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask
  function automatic logic [128:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic [63:0] ux, uy, q, r;
    if (y == 0) return {64'd0, x, 1'b1};
    ux = (s && x[63]) ? -x : x;
    uy = (s && y[63]) ? -y : y;
    q = ux / uy;
    r = ux % uy;
    if (s && (x[63] ^ y[63])) q = -q;
    if (s && x[63]) r = -r;
    return {q, r, 1'b0};
  endfunction
  task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic s, input bit hold);
    a = x;
    b = y;
    is_signed = s;
    start = 1'b1;
    sb_q.push_back(model(x, y, s));
    @(posedge clk);
    @(negedge clk);
    start = hold;
    if (!hold) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      is_signed = 1'(($urandom));
    end
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask
  task automatic finish_op(input string tag, input int exp_lat);
    int lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    exp_r = sb_q.pop_front();
    chk({tag, "_q"}, quotient, exp_r[128:65]);
    chk({tag, "_r"}, remainder, exp_r[64:1]);
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_r[0]));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_done_after"}, 64'(done), 64'd0);
    chk({tag, "_q_hold"}, quotient, exp_r[128:65]);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    issue(64'd100, 64'd7, 1'b0, 1'b0);
    finish_op("udiv", 65);
    issue(-64'sd100, 64'd7, 1'b1, 1'b0);
    finish_op("sdiv_nd", 65);
    issue(64'd100, -64'sd7, 1'b1, 1'b0);
    finish_op("sdiv_dn", 65);
    issue(-64'sd100, -64'sd7, 1'b1, 1'b0);
    finish_op("sdiv_nn", 65);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0);
    finish_op("udiv_max", 65);
    issue(64'h1234, 64'd0, 1'b0, 1'b0);
    finish_op("dbz_u", 1);
    issue(64'h1234, 64'd0, 1'b1, 1'b0);
    finish_op("dbz_s", 1);
    issue(64'd10, 64'd3, 1'b0, 1'b0);
    finish_op("after_dbz", 65);
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    finish_op("ovf", 65);
    issue(64'h8000_0000_0000_0000, 64'd3, 1'b1, 1'b0);
    finish_op("min_div3", 65);
    issue(64'd50, 64'd5, 1'b0, 1'b1);
    a = 64'd9;
    b = 64'd3;
    sb_q.push_back(model(64'd9, 64'd3, 1'b0));
    finish_op("held_first", 65);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("held_second_busy", 64'(busy), 64'd1);
    finish_op("held_second", 65);
    issue(64'd1000, 64'd3, 1'b0, 1'b0);
    repeat (29) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    void'(sb_q.pop_front());
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_q", quotient, 64'd0);
    chk("abort_r", remainder, 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    dones = 0;
    repeat (75) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    issue(64'd81, 64'd9, 1'b0, 1'b0);
    finish_op("after_abort", 65);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative 64-bit integer divider for UDIV/SDIV. It is the multi-cycle counterpart of the single-cycle ALU and sits beside it in the execute stage, sharing the same `a`/`b` operand buses. Control holds the core stalled while `busy` is high and captures `quotient` when `done` pulses. The divider uses a radix-2 restoring algorithm with a start/busy/done handshake.

## Interface

Parameters:
- `N`, 64, operand and result width.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  reset; **synchronous and active-low** (0 = reset).
- `a`  input  N  dividend; sampled only when a start is accepted.
- `b`  input  N  divisor; sampled only when a start is accepted.
- `is_signed`  input  1  1 = SDIV (two's complement), 0 = UDIV; sampled with the operands.
- `start`  input  1  request; accepted only in IDLE.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  one-cycle pulse; results are valid from this cycle onward.
- `quotient`  output  N  registered result.
- `remainder`  output  N  registered result.
- `div_by_zero`  output  1  registered; set with `done` when `b` was 0.

## Operation

States:
- **IDLE → RUN**: `start` = 1 and `b` ≠ 0.
  - Latch unsigned magnitudes: |a| and |b| when `is_signed`, else raw `a` and `b`.
  - Latch the sign flags `neg_q` = sign(a)^sign(b) and `neg_r` = sign(a), both gated by `is_signed`.
  - Set `cnt` = N−1.
  - Clear the partial remainder, `div_by_zero`, and the result registers.
- **IDLE → DONE**: `start` = 1 and `b` = 0.
  - `quotient` = 0, `remainder` = `a` unchanged, `div_by_zero` = 1.
- **RUN**: one step per cycle.
  - Shift the remainder left, bringing in the dividend MSB.
  - Trial-subtract the divisor at N+1 bits.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - When `cnt` = 0, write the results and go to DONE; otherwise decrement `cnt`.
- **Result write**:
  - `quotient` = `neg_q` ? −q : q.
  - `remainder` = `neg_r` ? −r : r.
  - Division truncates toward zero; the remainder takes the dividend's sign.
- **DONE**: `done` = 1 for exactly this cycle, then → IDLE unconditionally.

Arithmetic rules:
- Magnitudes are computed as N-bit unsigned. |−2^63| = 0x8000_0000_0000_0000 is valid as an unsigned value.
- Signed overflow (−2^63 / −1) wraps: quotient = 0x8000_0000_0000_0000, remainder = 0. This falls out of the algorithm; there is no special case.
- Result negation is modulo 2^N.

Boundary rules:
- `start` while `busy` (RUN or DONE) is ignored, with no queueing. `start` in the DONE cycle is also ignored.
- Operand inputs are don't-care except in the accept cycle.
- `quotient`, `remainder` and `div_by_zero` hold their values from DONE until the next accepted start clears them.
- Reset asserted in any state, including mid-RUN:
  - Next state is IDLE.
  - All outputs and internal registers go to 0.
  - No `done` pulse is produced for the aborted operation.

## Timing

Reset values:
- `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0; state = IDLE.

Latency (start accepted at edge E0):
- **Nonzero divisor:**
  - RUN steps occur on edges E1..E64.
  - `done` is high in the cycle after E64 (65 cycles after accept).
  - `busy` is high from after E0 through the DONE cycle.
  - The next start can be accepted at edge E66.
- **Zero divisor:**
  - `done` is high in the cycle after E0 (latency 1).
  - The next start can be accepted at E2.

Throughput:
- One operation per 66 cycles for a nonzero divisor.
- One operation per 2 cycles for a zero divisor.

Output timing:
- `busy` and `done` decode directly from the state register, with no combinational path from `start`.

## Test plan

- **UDIV**: a = 100, b = 7, `is_signed` = 0, 1-cycle start → `busy` rises next cycle; `done` pulses exactly 65 cycles after accept; `quotient` = 14, `remainder` = 2, `div_by_zero` = 0; `busy` = 0 the cycle after.
- **SDIV signs**: −100/7 → q = −14, r = −2; 100/−7 → q = −14, r = 2; −100/−7 → q = 14, r = −2; UDIV of 0xFFFF_FFFF_FFFF_FFFF / 2 → q = 0x7FFF_FFFF_FFFF_FFFF, r = 1.
- **Divide by zero**: a = 0x1234, b = 0, both signednesses → `done` the cycle after accept; q = 0, r = 0x1234, `div_by_zero` = 1. The following 10/3 → `div_by_zero` = 0, q = 3, r = 1.
- **Signed overflow**: a = 0x8000_0000_0000_0000, b = 0xFFFF_FFFF_FFFF_FFFF, `is_signed` = 1 → q = 0x8000_0000_0000_0000, r = 0.
- **Start while busy**:
  - Start 50/5, then hold `start` high with a = 9, b = 3 through RUN and DONE → exactly one `done`, with q = 10, r = 0.
  - The held `start` is accepted in the IDLE cycle after DONE, and the second op returns q = 3, r = 0.
- **Reset mid-operation**:
  - Drive `reset` = 0 for one cycle at RUN step 30 → next cycle `busy` = 0 and all outputs are 0.
  - No `done` pulses for ≥70 cycles.
  - A new 81/9 then returns q = 9, r = 0 with the normal 65-cycle latency.
